// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift_reg_ctrl serialiser: FSM state encoding,
// default word width and the parity helper.
// Optional feature macro: SHIFT_CTRL_PARITY_EN (trailing even-parity bit).
package shift_ctrl_pkg;

  // Encoding is fixed so that state values stay stable across builds.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // Even-parity bit: makes the total count of ones (word + parity) even.
  // Callers zero-extend narrower words, which does not change the result.
  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-in / serial-out shift register with synchronous parallel load,
// shift enable, compile-time shift direction and a serial fill input.
// The serial output is a direct register tap, so it is glitch-free.
module shift_reg_piso
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_en_i,
  input  logic             fill_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_shifted;

  // Per-bit shifted value; the vacated end takes the fill bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (MSB_FIRST != 0) begin : g_msb
        if (gi == 0) begin : g_in
          assign sh_shifted[gi] = fill_i;
        end else begin : g_mid
          assign sh_shifted[gi] = sh_q[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_in
          assign sh_shifted[gi] = fill_i;
        end else begin : g_mid
          assign sh_shifted[gi] = sh_q[gi+1];
        end
      end
    end
  endgenerate

  // Shift register: load has priority over shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else if (load_i) begin
      sh_q <= data_i;
    end else if (shift_en_i) begin
      sh_q <= sh_shifted;
    end
  end

  assign ser_o = (MSB_FIRST != 0) ? sh_q[WIDTH-1] : sh_q[0];

endmodule

// File: rtl/shift_reg_ctrl.sv
// Serialiser controller: accepts a parallel word with a valid/ready handshake
// and emits it one bit per cycle, with a stall input and a done pulse.
// Optional feature macro: SHIFT_CTRL_PARITY_EN appends one even-parity bit.
// Registered outputs (ser_valid, busy, done) are computed from the next
// state so they describe the cycle that follows each clock edge; hold seen
// at an edge therefore blanks ser_valid for the following cycle.
module shift_reg_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_valid_q, ser_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_en;
  logic             shift_en;
  logic             fill_bit;

`ifdef SHIFT_CTRL_PARITY_EN
  logic parity_q;

  // Parity of the accepted word, captured alongside the parallel load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (load_en) begin
      parity_q <= even_parity(16'(in_data));
    end
  end

  // Filling with the parity bit means the WIDTH-th shift lands it on the tap.
  assign fill_bit = parity_q;
`else
  assign fill_bit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus next values of counter and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_en     = 1'b0;
    shift_en    = 1'b0;
    ser_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load_en = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // The bit on the tap was already presented; advance unless stalled.
        if (!hold) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
`ifdef SHIFT_CTRL_PARITY_EN
            state_d  = ST_PARITY;
            shift_en = 1'b1;
`else
            state_d  = ST_DONE;
`endif
          end else begin
            shift_en = 1'b1;
          end
        end
      end
`ifdef SHIFT_CTRL_PARITY_EN
      ST_PARITY: begin
        if (!hold) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    // The acceptance edge always presents the first bit; later edges stall on hold.
    ser_valid_d = busy_d && ((state_q == ST_IDLE) || !hold);
    done_d      = (state_d == ST_DONE);
  end

  // Bit counter and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ser_valid_q <= ser_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  shift_reg_piso #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk        (clk),
    .rst        (reset),
    .load_i     (load_en),
    .data_i     (in_data),
    .shift_en_i (shift_en),
    .fill_i     (fill_bit),
    .ser_o      (ser_out)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign ser_valid = ser_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: one MSB-first and one LSB-first instance share
// stimulus; expected frames come from a list-based model of the bit sequence.
// Honours SHIFT_CTRL_PARITY_EN when the design is built with it.
module tb_shift_reg_ctrl;

  localparam int W = 4;
`ifdef SHIFT_CTRL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         hold = 1'b0;
  logic in_ready_m, ser_out_m, ser_valid_m, busy_m, done_m;
  logic in_ready_l, ser_out_l, ser_valid_l, busy_l, done_l;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  shift_reg_ctrl #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .hold(hold), .ser_out(ser_out_m),
    .ser_valid(ser_valid_m), .busy(busy_m), .done(done_m)
  );

  shift_reg_ctrl #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .hold(hold), .ser_out(ser_out_l),
    .ser_valid(ser_valid_l), .busy(busy_l), .done(done_l)
  );

  // Drives one frame starting from an idle sample point and checks every
  // cycle until the controller is idle again. hold_mask[c] is the hold level
  // driven during cycle c after acceptance. stream keeps in_valid high with
  // junk data throughout, which must not be captured.
  task automatic run_frame(input logic [W-1:0] data, input logic [31:0] hold_mask,
                           input bit stream, input string name);
    bit q_m[$];
    bit q_l[$];
    int n;
    int idx;
    int c;
    bit prev_hold;
    bit done_seen;
    logic [4:0] exp_m, exp_l, got_m, got_l;
    for (int i = 0; i < W; i++) begin
      q_m.push_back(data[W-1-i]);
      q_l.push_back(data[i]);
    end
    if (PAR) begin
      q_m.push_back(($countones(data) % 2) == 1);
      q_l.push_back(($countones(data) % 2) == 1);
    end
    n = q_m.size();

    vectors++;
    if ({in_ready_m, in_ready_l} !== 2'b11) begin
      errors++;
      $display("FAIL %s ready-before-accept: got %b want 11", name, {in_ready_m, in_ready_l});
    end
    in_data  = data;
    in_valid = 1'b1;
    hold     = 1'b0;

    idx = 0;
    prev_hold = 1'b0;
    done_seen = 1'b0;
    c = 0;
    while (!done_seen && c < 64) begin
      @(posedge clk);
      #1;
      c++;
      if (c > 1 && !prev_hold) idx++;
      got_m = {in_ready_m, ser_valid_m, busy_m, done_m, ser_out_m};
      got_l = {in_ready_l, ser_valid_l, busy_l, done_l, ser_out_l};
      if (idx >= n) begin
        done_seen = 1'b1;
        vectors++;
        if (got_m[4:1] !== 4'b0001 || got_l[4:1] !== 4'b0001) begin
          errors++;
          $display("FAIL %s done-cycle %0d: got msb=%b lsb=%b want 0001 (ready,valid,busy,done)",
                   name, c, got_m[4:1], got_l[4:1]);
        end
      end else begin
        exp_m = {1'b0, !prev_hold, 1'b1, 1'b0, q_m[idx]};
        exp_l = {1'b0, !prev_hold, 1'b1, 1'b0, q_l[idx]};
        vectors++;
        if (got_m !== exp_m || got_l !== exp_l) begin
          errors++;
          $display("FAIL %s bit-cycle %0d: got msb=%b lsb=%b want msb=%b lsb=%b (ready,valid,busy,done,ser)",
                   name, c, got_m, got_l, exp_m, exp_l);
        end
      end
      in_valid = stream;
      if (stream) in_data = W'($urandom);
      prev_hold = done_seen ? 1'b0 : ((c < 32) ? hold_mask[c[4:0]] : 1'b0);
      hold = prev_hold;
    end
    if (!done_seen) begin
      vectors++;
      errors++;
      $display("FAIL %s frame-timeout: got no done after %0d cycles, want done", name, c);
    end
    hold = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({in_ready_m, ser_valid_m, busy_m, done_m} !== 4'b1000 ||
        {in_ready_l, ser_valid_l, busy_l, done_l} !== 4'b1000) begin
      errors++;
      $display("FAIL %s idle-after-done: got msb=%b lsb=%b want 1000",
               name, {in_ready_m, ser_valid_m, busy_m, done_m},
               {in_ready_l, ser_valid_l, busy_l, done_l});
    end
    $display("frame %s data=%b holds=%b stream=%0d cycles=%0d", name, data, hold_mask[15:0], stream, c);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 4'b1111;
    repeat (3) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({in_ready_m, ser_valid_m, busy_m, done_m, ser_out_m} !== 5'b10000 ||
          {in_ready_l, ser_valid_l, busy_l, done_l, ser_out_l} !== 5'b10000) begin
        errors++;
        $display("FAIL reset-state: got msb=%b lsb=%b want 10000",
                 {in_ready_m, ser_valid_m, busy_m, done_m, ser_out_m},
                 {in_ready_l, ser_valid_l, busy_l, done_l, ser_out_l});
      end
    end
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({in_ready_m, busy_m, in_ready_l, busy_l} !== 4'b1010) begin
      errors++;
      $display("FAIL post-reset-idle: got %b want 1010", {in_ready_m, busy_m, in_ready_l, busy_l});
    end
    $display("reset sequence checked");
  endtask

  task automatic test_basic();
    run_frame(4'b1011, 32'h0, 1'b0, "basic_1011");
    run_frame(4'b0001, 32'h0, 1'b0, "order_0001");
  endtask

  task automatic test_hold();
    run_frame(4'b1100, 32'h0000_001C, 1'b0, "hold_1100");
    run_frame(4'b0110, 32'h0000_0030, 1'b0, "hold_tail");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      run_frame(W'($urandom), 32'h0, 1'b1, "stream");
    end
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] d;
    d = W'($urandom);
    in_data = d;
    in_valid = 1'b1;
    hold = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      vectors++;
      if ({in_ready_m, ser_valid_m, busy_m, done_m, ser_out_m} !== {4'b0110, d[W-c]} ||
          {in_ready_l, ser_valid_l, busy_l, done_l, ser_out_l} !== {4'b0110, d[c-1]}) begin
        errors++;
        $display("FAIL midframe-bit %0d: got msb=%b lsb=%b want msb=%b lsb=%b", c,
                 {in_ready_m, ser_valid_m, busy_m, done_m, ser_out_m},
                 {in_ready_l, ser_valid_l, busy_l, done_l, ser_out_l},
                 {4'b0110, d[W-c]}, {4'b0110, d[c-1]});
      end
    end
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if ({in_ready_m, ser_valid_m, busy_m, done_m, ser_out_m} !== 5'b10000 ||
        {in_ready_l, ser_valid_l, busy_l, done_l, ser_out_l} !== 5'b10000) begin
      errors++;
      $display("FAIL async-reset: got msb=%b lsb=%b want 10000",
               {in_ready_m, ser_valid_m, busy_m, done_m, ser_out_m},
               {in_ready_l, ser_valid_l, busy_l, done_l, ser_out_l});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({done_m, done_l, busy_m, busy_l} !== 4'b0000) begin
      errors++;
      $display("FAIL reset-no-done: got %b want 0000", {done_m, done_l, busy_m, busy_l});
    end
    reset = 1'b0;
    $display("midframe reset data=%b checked", d);
    run_frame(W'($urandom), 32'h0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      run_frame(W'($urandom), ($urandom & $urandom) & 32'h0000_1FFE,
                1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
